// File: rtl/cfg_scan_pkg.sv
// Shared definitions for the configuration scan-chain loader: FSM encoding and the CRC-8 step.
// The CRC helpers are only referenced when the loader is built with CFG_CRC_EN.
package cfg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One serial MSB-first CRC-8 update: feedback is the outgoing MSB xor the new bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00); one bit per enabled cycle.
// Used only by cfg_scan_loader builds with CFG_CRC_EN defined.
module cfg_crc8
    import cfg_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/cfg_scan_loader.sv
// Serialises a valid/ready word stream into the configuration scan chain, LSB first, for exactly
// CHAIN_LEN shifts. Optional macro CFG_CRC_EN adds CRC-8 signatures crc_in (written) and crc_rb (read back).
module cfg_scan_loader
    import cfg_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              chain_scan_en,
    output logic              chain_wen,
    output logic              chain_scan_in,
    input  logic              chain_scan_out
`ifdef CFG_CRC_EN
    ,
    output logic [7:0]        crc_in,
    output logic [7:0]        crc_rb
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  LAST_WBIT = WC_W'(WORD_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   wbit_cnt;
    logic [WORD_W-1:0] sreg;
    logic              start_ok;
    logic              xfer;

    // Stream handshake: a word moves on a rising clk edge where s_valid && s_ready.
    // s_ready is high only in LOAD and is withdrawn during abort, so an aborted cycle never transfers.
    assign xfer     = s_valid & s_ready;
    assign start_ok = (state == ST_IDLE) & start & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    if (s_valid) state_nx = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Chain length wins over word length: leftover word bits are dropped.
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = ST_DONE;
                    end else if (wbit_cnt == LAST_WBIT) begin
                        state_nx = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        s_ready       = 1'b0;
        chain_scan_en = 1'b0;
        chain_wen     = 1'b0;
        case (state)
            ST_LOAD: begin
                busy          = 1'b1;
                s_ready       = ~abort;
                chain_scan_en = 1'b1;
            end
            ST_SHIFT: begin
                busy          = 1'b1;
                chain_scan_en = 1'b1;
                chain_wen     = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            wbit_cnt <= '0;
            sreg     <= '0;
        end else begin
            if (start_ok) begin
                bit_cnt <= '0;
            end
            if (xfer) begin
                sreg     <= s_data;
                wbit_cnt <= '0;
            end
            if (state == ST_SHIFT) begin
                sreg     <= sreg >> 1;
                bit_cnt  <= bit_cnt + CNT_W'(1);
                wbit_cnt <= wbit_cnt + WC_W'(1);
            end
        end
    end

    // Serial data comes straight off the shift-register flop, so it is glitch-free at the chain.
    assign chain_scan_in = sreg[0];

`ifdef CFG_CRC_EN
    cfg_crc8 u_crc_in (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (chain_wen),
        .din (chain_scan_in),
        .crc (crc_in)
    );

    cfg_crc8 u_crc_rb (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (chain_wen),
        .din (chain_scan_out),
        .crc (crc_rb)
    );
`else
    logic unused_scan_out;
    assign unused_scan_out = chain_scan_out;
`endif

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Directed bench for cfg_scan_loader: two instances (16-cell and 10-cell chains) with chain models.
// Build with CFG_CRC_EN defined to include the CRC readback step.
module tb_cfg_scan_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       sel;
    logic       chain_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic start16, start10;
    assign start16 = start & ~sel;
    assign start10 = start & sel;

    logic busy16, done16, ready16, scan_en16, wen16, scan_in16;
    logic busy10, done10, ready10, scan_en10, wen10, scan_in10;
    logic [15:0] chain16;
    logic [9:0]  chain10;
`ifdef CFG_CRC_EN
    logic [7:0] crc_in16, crc_rb16, crc_in10, crc_rb10;
`endif

    cfg_scan_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .clk            (clk),
        .rst            (rst),
        .start          (start16),
        .abort          (abort),
        .busy           (busy16),
        .done           (done16),
        .s_valid        (s_valid),
        .s_ready        (ready16),
        .s_data         (s_data),
        .chain_scan_en  (scan_en16),
        .chain_wen      (wen16),
        .chain_scan_in  (scan_in16),
        .chain_scan_out (chain16[15])
`ifdef CFG_CRC_EN
        ,
        .crc_in         (crc_in16),
        .crc_rb         (crc_rb16)
`endif
    );

    cfg_scan_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
        .clk            (clk),
        .rst            (rst),
        .start          (start10),
        .abort          (abort),
        .busy           (busy10),
        .done           (done10),
        .s_valid        (s_valid),
        .s_ready        (ready10),
        .s_data         (s_data),
        .chain_scan_en  (scan_en10),
        .chain_wen      (wen10),
        .chain_scan_in  (scan_in10),
        .chain_scan_out (chain10[9])
`ifdef CFG_CRC_EN
        ,
        .crc_in         (crc_in10),
        .crc_rb         (crc_rb10)
`endif
    );

    // External chain models: cell 0 takes scan_in, each cell feeds the next.
    always @(posedge clk) begin
        if (chain_clr) begin
            chain16 <= '0;
            chain10 <= '0;
        end else begin
            if (wen16) chain16 <= {chain16[14:0], scan_in16};
            if (wen10) chain10 <= {chain10[8:0], scan_in10};
        end
    end

    logic        o_busy, o_done, o_ready, o_scan_en, o_wen, o_scan_in;
    logic [15:0] o_chain;
    assign o_busy    = sel ? busy10    : busy16;
    assign o_done    = sel ? done10    : done16;
    assign o_ready   = sel ? ready10   : ready16;
    assign o_scan_en = sel ? scan_en10 : scan_en16;
    assign o_wen     = sel ? wen10     : wen16;
    assign o_scan_in = sel ? scan_in10 : scan_in16;
    assign o_chain   = sel ? {6'b0, chain10} : chain16;

    int          wen_cnt, done_cnt, xfer_cnt, busy_at_done, ready_late, gap_bad, gap_cnt;
    logic [31:0] seq;
    logic        pa_busy, pa_wen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [31:0] bits, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // One load over a fixed cycle window; records everything the checks need.
    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                           input int abort_at, input int mid_start_at);
        int          idx;
        logic        xfer;
        logic        aborted_prev;
        logic [15:0] snap;
        wen_cnt = 0; done_cnt = 0; xfer_cnt = 0; busy_at_done = 0;
        ready_late = 0; gap_bad = 0; gap_cnt = 0; seq = '0;
        pa_busy = 1'bx; pa_wen = 1'bx;
        idx = 0; aborted_prev = 1'b0; snap = '0;
        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            abort = 1'b0;
            start = 1'b0;
            if (aborted_prev) begin
                pa_busy = o_busy;
                pa_wen  = o_wen;
                aborted_prev = 1'b0;
            end
            if (o_wen) begin
                if (wen_cnt == abort_at) begin
                    abort = 1'b1;
                    aborted_prev = 1'b1;
                end
                if (wen_cnt == mid_start_at) start = 1'b1;
                seq[wen_cnt] = o_scan_in;
                wen_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                if (o_busy) busy_at_done++;
            end
            if (idx >= 2 && o_ready) ready_late++;
            if (idx == 1 && o_ready && gap_cnt < gap) begin
                s_valid = 1'b0;
                if (gap_cnt == 0) snap = o_chain;
                else if (o_chain !== snap) gap_bad++;
                if (o_wen) gap_bad++;
                gap_cnt++;
            end else begin
                s_valid = 1'b1;
                s_data  = (idx == 0) ? w0 : ((idx == 1) ? w1 : 8'hEE);
            end
            #1;
            xfer = s_valid & o_ready;
            @(negedge clk);
            if (xfer) begin
                idx++;
                xfer_cnt++;
            end
        end
        s_valid = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
    endtask

`ifdef CFG_CRC_EN
    logic [7:0] exp_crc;
`endif

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        sel = 1'b0; chain_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",    busy16,    0);
        check("rst_done",    done16,    0);
        check("rst_ready",   ready16,   0);
        check("rst_scan_en", scan_en16, 0);
        check("rst_wen",     wen16,     0);
        check("rst_scan_in", scan_in16, 0);
        rst = 1'b0;
        chain_clr = 1'b0;
        @(negedge clk);

        // Two full words into a 16-cell chain.
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        check("t1_wen_cycles", wen_cnt, 16);
        check("t1_scan_seq",   seq, 32'h0000_3CA5);
        check("t1_done_once",  done_cnt, 1);
        check("t1_busy_done",  busy_at_done, 0);
        check("t1_xfers",      xfer_cnt, 2);
        check("t1_chain",      chain16, 16'hA53C);
        check("t1_idle_busy",  o_busy, 0);

        // 10-cell chain: only two bits of the second word are used.
        sel = 1'b1;
        do_load(8'hFF, 8'h01, 0, -1, -1);
        check("t2_wen_cycles", wen_cnt, 10);
        check("t2_scan_seq",   seq, 32'h0000_01FF);
        check("t2_xfers",      xfer_cnt, 2);
        check("t2_ready_late", ready_late, 0);
        check("t2_done_once",  done_cnt, 1);
        check("t2_chain",      chain10, 10'h3FE);
        sel = 1'b0;

        // Five-cycle stall between words.
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
        do_load(8'hA5, 8'h3C, 5, -1, -1);
        check("t3_gap_len",    gap_cnt, 5);
        check("t3_gap_hold",   gap_bad, 0);
        check("t3_wen_cycles", wen_cnt, 16);
        check("t3_chain",      chain16, 16'hA53C);
        check("t3_done_once",  done_cnt, 1);

        // Abort after five shifts, then a clean reload.
        do_load(8'hA5, 8'h3C, 0, 5, -1);
        check("t4_wen_cycles", wen_cnt, 6);
        check("t4_no_done",    done_cnt, 0);
        check("t4_busy_after", pa_busy, 0);
        check("t4_wen_after",  pa_wen, 0);
        check("t4_xfers",      xfer_cnt, 1);
        do_load(8'h3C, 8'hA5, 0, -1, -1);
        check("t4_reload_wen",   wen_cnt, 16);
        check("t4_reload_done",  done_cnt, 1);
        check("t4_reload_chain", chain16, 16'h3CA5);

        // start while busy is ignored.
        do_load(8'hA5, 8'h3C, 0, -1, 3);
        check("t5_busy_start_wen",   wen_cnt, 16);
        check("t5_busy_start_seq",   seq, 32'h0000_3CA5);
        check("t5_busy_start_done",  done_cnt, 1);
        check("t5_busy_start_chain", chain16, 16'hA53C);

        // start and abort together in IDLE.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t5_sa_busy",  o_busy, 0);
        check("t5_sa_ready", o_ready, 0);
        @(negedge clk);
        check("t5_sa_busy2", o_busy, 0);

        // Asynchronous reset in the middle of SHIFT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_pre_wen",     o_wen, 1);
        check("t5_pre_scan_in", o_scan_in, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy",    o_busy, 0);
        check("t5_rst_done",    o_done, 0);
        check("t5_rst_ready",   o_ready, 0);
        check("t5_rst_scan_en", o_scan_en, 0);
        check("t5_rst_wen",     o_wen, 0);
        check("t5_rst_scan_in", o_scan_in, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef CFG_CRC_EN
        // CRC: blank chain reads back zero, then the second load reads back the first.
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
        exp_crc = crc8_ref(32'h0000_3CA5, 16);
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        check("t6_crc_rb_blank", crc_rb16, 8'h00);
        check("t6_crc_in_first", crc_in16, exp_crc);
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        check("t6_crc_rb_second", crc_rb16, exp_crc);
        check("t6_crc_in_second", crc_in16, exp_crc);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
